// File: rtl/fc_pkg.sv
// fc_pkg: default sizes, FSM state type and width helpers
// shared by the streaming fully-connected layer and its MAC lanes.
package fc_pkg;

   localparam int FC_IN_LEN   = 1152;
   localparam int FC_N_OUT    = 10;
   localparam int FC_DATA_W   = 69;
   localparam int FC_WEIGHT_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCAN,
      DONE
   } fc_state_e;

   function automatic int fc_acc_w(input int dw, input int ww, input int n);
      return dw + ww + $clog2(n);
   endfunction

   function automatic int fc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane.
// Ports: clk, rst (async active-low), load (acc = init + a*w),
//   acc_en (acc += a*w), in_data, weight, init, acc (result).
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int DATA_W   = FC_DATA_W,
   parameter int WEIGHT_W = FC_WEIGHT_W,
   parameter int ACC_W    = fc_acc_w(FC_DATA_W, FC_WEIGHT_W, FC_IN_LEN)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       acc_en,
   input  logic signed [DATA_W-1:0]   in_data,
   input  logic signed [WEIGHT_W-1:0] weight,
   input  logic signed [ACC_W-1:0]    init,
   output logic signed [ACC_W-1:0]    acc
);

   localparam int PW = DATA_W + WEIGHT_W;

   logic signed [PW-1:0]    a_ext;
   logic signed [PW-1:0]    w_ext;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   // PW bits hold the full signed product exactly
   always_comb begin
      a_ext    = PW'(in_data);
      w_ext    = PW'(weight);
      prod     = a_ext * w_ext;
      prod_ext = ACC_W'(prod);
      acc_d    = acc_q;
      if (load) begin
         acc_d = init + prod_ext;
      end else if (acc_en) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fc_stream_layer.sv
// fc_stream_layer: streaming FC layer, N_OUT parallel MACs per beat,
// then a one-lane-per-cycle argmax scan and a valid/ready result.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_data/
//   in_weight/in_last, out_valid/out_ready/out_score/out_class,
//   frame_err (sticky). Macro FC_BIAS_EN adds in_bias, loaded on
//   the first beat of each frame.
module fc_stream_layer
   import fc_pkg::*;
#(
   parameter int IN_LEN   = FC_IN_LEN,
   parameter int N_OUT    = FC_N_OUT,
   parameter int DATA_W   = FC_DATA_W,
   parameter int WEIGHT_W = FC_WEIGHT_W,
   parameter int ACC_W    = fc_acc_w(DATA_W, WEIGHT_W, IN_LEN),
   parameter int IDX_W    = fc_idx_w(N_OUT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_data,
   input  logic [N_OUT*WEIGHT_W-1:0] in_weight,
   input  logic                      in_last,
`ifdef FC_BIAS_EN
   input  logic [N_OUT*WEIGHT_W-1:0] in_bias,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_OUT*ACC_W-1:0]    out_score,
   output logic [IDX_W-1:0]          out_class,
   output logic                      frame_err
);

   localparam int CNT_W = $clog2(IN_LEN + 1);

   fc_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [IDX_W-1:0]        best_idx_q, best_idx_d;
   logic signed [ACC_W-1:0] best_val_q, best_val_d;
   logic                    err_q, err_d;
   logic                    live_q, live_d;

   logic signed [ACC_W-1:0] acc [N_OUT];
   logic                    fire;
   logic                    lane_load;
   logic                    lane_acc;
   logic [CNT_W-1:0]        beat_cnt;
   logic                    at_len;
   logic                    take;

   // in_ready stays low until the first edge after reset release
   assign in_ready  = live_q &&
                      (state_q == IDLE || state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign out_class = best_idx_q;
   assign frame_err = err_q;

   assign fire      = in_valid && in_ready;
   assign lane_load = fire && (state_q == IDLE);
   assign lane_acc  = fire && (state_q == ACCUM);
   assign beat_cnt  = (state_q == IDLE) ? CNT_W'(1)
                                        : cnt_q + CNT_W'(1);
   assign at_len    = (beat_cnt == CNT_W'(IN_LEN));

   // lane 0 seeds the best; later lanes need strictly greater
   assign take = (idx_q == '0) || (acc[idx_q] > best_val_q);

   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      logic signed [ACC_W-1:0] init_k;
`ifdef FC_BIAS_EN
      assign init_k =
         ACC_W'($signed(in_bias[k*WEIGHT_W +: WEIGHT_W]));
`else
      assign init_k = '0;
`endif
      fc_mac_lane #(
         .DATA_W   (DATA_W),
         .WEIGHT_W (WEIGHT_W),
         .ACC_W    (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .load     (lane_load),
         .acc_en   (lane_acc),
         .in_data  (in_data),
         .weight   (in_weight[k*WEIGHT_W +: WEIGHT_W]),
         .init     (init_k),
         .acc      (acc[k])
      );
      assign out_score[k*ACC_W +: ACC_W] = out_valid ? acc[k] : '0;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
      err_d      = err_q;
      live_d     = 1'b1;
      unique case (state_q)
         IDLE, ACCUM: begin
            if (fire) begin
               cnt_d = beat_cnt;
               if (in_last || at_len) begin
                  state_d = SCAN;
                  idx_d   = '0;
                  // frame ended by one condition but not the other
                  if (in_last != at_len) begin
                     err_d = 1'b1;
                  end
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         SCAN: begin
            if (take) begin
               best_idx_d = idx_q;
               best_val_d = acc[idx_q];
            end
            if (idx_q == IDX_W'(N_OUT - 1)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         err_q      <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
         err_q      <= err_d;
         live_q     <= live_d;
      end
   end

endmodule

// File: tb/tb_fc_stream_layer.sv
// tb_fc_stream_layer: scoreboard bench for fc_stream_layer with a
// behavioural sum-of-products / argmax reference model.
module tb_fc_stream_layer;

   localparam int IN_LEN   = 4;
   localparam int N_OUT    = 3;
   localparam int DATA_W   = 69;
   localparam int WEIGHT_W = 32;
   localparam int ACC_W    = DATA_W + WEIGHT_W + $clog2(IN_LEN);
   localparam int IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int SW       = N_OUT * ACC_W;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic signed [DATA_W-1:0]  in_data;
   logic [N_OUT*WEIGHT_W-1:0] in_weight;
   logic                      in_last;
`ifdef FC_BIAS_EN
   logic [N_OUT*WEIGHT_W-1:0] in_bias;
`endif
   logic                      out_valid;
   logic                      out_ready;
   logic [SW-1:0]             out_score;
   logic [IDX_W-1:0]          out_class;
   logic                      frame_err;

   typedef struct packed {
      logic [SW-1:0]    score;
      logic [IDX_W-1:0] cls;
      logic             err;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   edge_n = 0;
   int   last_acc = 0;
   int   out_mode = 1;
   bit   err_model = 1'b0;
   bit   ov_prev = 1'b0;
   bit   hs_prev = 1'b0;

   logic signed [DATA_W-1:0]   fd [IN_LEN];
   logic signed [WEIGHT_W-1:0] fw [IN_LEN][N_OUT];
   logic signed [WEIGHT_W-1:0] fb [N_OUT];

   fc_stream_layer #(
      .IN_LEN   (IN_LEN),
      .N_OUT    (N_OUT),
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_weight (in_weight),
      .in_last   (in_last),
`ifdef FC_BIAS_EN
      .in_bias   (in_bias),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_score (out_score),
      .out_class (out_class),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic checkv(input string nm, input logic [SW-1:0] act,
                         input logic [SW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act,
                         input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Reference: score[k] = bias[k] + sum over beats of data*weight
   function automatic exp_t model(input int len);
      exp_t e;
      logic signed [ACC_W-1:0] s [N_OUT];
      logic signed [ACC_W-1:0] a;
      logic signed [ACC_W-1:0] w;
      int best;
      for (int k = 0; k < N_OUT; k++) s[k] = ACC_W'(fb[k]);
      for (int b = 0; b < len; b++) begin
         for (int k = 0; k < N_OUT; k++) begin
            a = ACC_W'(fd[b]);
            w = ACC_W'(fw[b][k]);
            s[k] = s[k] + a * w;
         end
      end
      best = 0;
      for (int k = 1; k < N_OUT; k++) begin
         if (s[k] > s[best]) best = k;
      end
      e.score = '0;
      for (int k = 0; k < N_OUT; k++) e.score[k*ACC_W +: ACC_W] = s[k];
      e.cls = IDX_W'(best);
      e.err = 1'b0;
      return e;
   endfunction

   function automatic logic signed [DATA_W-1:0] rand_data();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[DATA_W-1:0];
   endfunction

   task automatic zero_bias();
      for (int k = 0; k < N_OUT; k++) fb[k] = '0;
   endtask

   task automatic rand_frame();
      for (int b = 0; b < IN_LEN; b++) begin
         fd[b] = rand_data();
         for (int k = 0; k < N_OUT; k++) fw[b][k] = $urandom;
      end
      zero_bias();
`ifdef FC_BIAS_EN
      for (int k = 0; k < N_OUT; k++) fb[k] = $urandom;
`endif
   endtask

   task automatic drive_beat(input int b, input bit last);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = fd[b];
      in_last  = last;
      for (int k = 0; k < N_OUT; k++)
         in_weight[k*WEIGHT_W +: WEIGHT_W] = fw[b][k];
`ifdef FC_BIAS_EN
      for (int k = 0; k < N_OUT; k++)
         in_bias[k*WEIGHT_W +: WEIGHT_W] = fb[k];
`endif
      while (!in_ready && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (!in_ready) fail("accept_timeout");
      @(posedge clk);
      #1;
      last_acc = edge_n;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_frame(input int len, input bit last_end,
                            input bit gaps);
      exp_t e;
      if (len != IN_LEN || !last_end) err_model = 1'b1;
      e = model(len);
      e.err = err_model;
      q.push_back(e);
      for (int b = 0; b < len; b++) begin
         drive_beat(b, last_end && (b == len - 1));
         if (gaps && b != len - 1) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((q.size() != 0 || out_valid) && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (q.size() != 0) fail("drain_timeout");
   endtask

   // Monitor: compares every presented result against the queue head
   always @(negedge clk) begin
      if (rst) begin
         if (hs_prev) begin
            check1("idle_in_ready", in_ready, 1'b1);
            check1("idle_out_valid", out_valid, 1'b0);
         end
         if (out_valid && !ov_prev)
            checkv("latency", SW'(edge_n - last_acc), SW'(N_OUT));
         if (out_valid) begin
            if (q.size() == 0) begin
               fail("unexpected_out");
            end else begin
               checkv("score", out_score, q[0].score);
               checkv("class", SW'(out_class), SW'(q[0].cls));
               check1("frame_err", frame_err, q[0].err);
               check1("busy_in_ready", in_ready, 1'b0);
               if (out_ready) void'(q.pop_front());
            end
         end
         hs_prev = out_valid && out_ready;
      end else begin
         hs_prev = 1'b0;
      end
      ov_prev = out_valid;
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (out_mode == 2) out_ready = 1'($urandom_range(0, 1));
         else out_ready = (out_mode == 1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_weight = '0;
      in_last   = 1'b0;
`ifdef FC_BIAS_EN
      in_bias   = '0;
`endif
      zero_bias();
      #12;
      check1("rst_out_valid", out_valid, 1'b0);
      checkv("rst_score", out_score, '0);
      checkv("rst_class", SW'(out_class), '0);
      check1("rst_frame_err", frame_err, 1'b0);
      check1("rst_in_ready", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check1("ready_before_edge", in_ready, 1'b0);
      @(posedge clk);
      #1;
      check1("ready_after_edge", in_ready, 1'b1);

      // directed: scores 10, -10, 2 (15 with bias 5 on lane 0)
      for (int b = 0; b < IN_LEN; b++) begin
         fd[b]    = DATA_W'(b + 1);
         fw[b][0] = WEIGHT_W'(1);
         fw[b][1] = WEIGHT_W'(-1);
         fw[b][2] = (b == 0) ? WEIGHT_W'(2) : '0;
      end
`ifdef FC_BIAS_EN
      fb[0] = WEIGHT_W'(5);
`endif
      run_frame(IN_LEN, 1'b1, 1'b0);
      wait_drain();

      // signed extremes, with input gaps
      zero_bias();
      for (int b = 0; b < IN_LEN; b++) begin
         fd[b] = '0;
         fd[b][DATA_W-1] = 1'b1;
         for (int k = 0; k < N_OUT; k++) begin
            fw[b][k] = '0;
            fw[b][k][WEIGHT_W-1] = 1'b1;
         end
      end
      run_frame(IN_LEN, 1'b1, 1'b1);
      wait_drain();

      // tie: identical lanes
      rand_frame();
      for (int b = 0; b < IN_LEN; b++) begin
         fw[b][1] = fw[b][0];
         fw[b][2] = fw[b][0];
      end
      fb[1] = fb[0];
      fb[2] = fb[0];
      run_frame(IN_LEN, 1'b1, 1'b0);
      wait_drain();

      // lane 2 strictly greatest
      zero_bias();
      for (int b = 0; b < IN_LEN; b++) begin
         fd[b]    = DATA_W'($urandom_range(1, 1000));
         fw[b][0] = WEIGHT_W'(1);
         fw[b][1] = WEIGHT_W'(1);
         fw[b][2] = WEIGHT_W'(2);
      end
      run_frame(IN_LEN, 1'b1, 1'b0);
      wait_drain();

      // backpressure: hold out_ready low for 20 cycles in DONE
      out_mode = 0;
      rand_frame();
      run_frame(IN_LEN, 1'b1, 1'b0);
      repeat (N_OUT + 20) @(posedge clk);
      #1;
      out_mode = 1;
      rand_frame();
      run_frame(IN_LEN, 1'b1, 1'b0);
      wait_drain();

      // random frames, gaps and random out_ready
      out_mode = 2;
      for (int f = 0; f < 8; f++) begin
         rand_frame();
         run_frame(IN_LEN, 1'b1, 1'b1);
      end
      wait_drain();
      out_mode = 1;

      // early in_last on beat 3, then a good frame keeps the error
      rand_frame();
      run_frame(3, 1'b1, 1'b1);
      wait_drain();
      zero_bias();
      for (int b = 0; b < IN_LEN; b++) begin
         fd[b]    = DATA_W'($urandom_range(1, 1000));
         fw[b][0] = WEIGHT_W'(-3);
         fw[b][1] = WEIGHT_W'(1);
         fw[b][2] = WEIGHT_W'(4);
      end
      run_frame(IN_LEN, 1'b1, 1'b0);
      wait_drain();

      // reset during ACCUM beat 2 discards the frame
      rand_frame();
      drive_beat(0, 1'b0);
      in_valid = 1'b1;
      in_data  = fd[1];
      #2;
      rst = 1'b0;
      #1;
      check1("mid_rst_out_valid", out_valid, 1'b0);
      checkv("mid_rst_score", out_score, '0);
      checkv("mid_rst_class", SW'(out_class), '0);
      check1("mid_rst_frame_err", frame_err, 1'b0);
      check1("mid_rst_in_ready", in_ready, 1'b0);
      in_valid  = 1'b0;
      err_model = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int b = 0; b < IN_LEN; b++) begin
         fd[b]    = DATA_W'(b + 1);
         fw[b][0] = WEIGHT_W'(1);
         fw[b][1] = WEIGHT_W'(-1);
         fw[b][2] = (b == 0) ? WEIGHT_W'(2) : '0;
      end
      zero_bias();
`ifdef FC_BIAS_EN
      fb[0] = WEIGHT_W'(5);
`endif
      run_frame(IN_LEN, 1'b1, 1'b0);
      wait_drain();

      // IN_LEN reached without in_last also flags the frame
      rand_frame();
      run_frame(IN_LEN, 1'b0, 1'b0);
      wait_drain();

      checkv("queue_empty", SW'(q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fc_stream_layer.md
Name: fc_stream_layer

Overview:
- Parametrised streaming fully-connected layer: consumes one flattened pooled activation per accepted beat, with that element's weights for all N_OUT neurons on the same beat.
- Performs N_OUT parallel signed MACs per beat, then runs a sequential argmax scan.
- Presents N_OUT scores plus the winning class on a valid/ready output.
- Sits between pool/ReLU stage and the classifier result logic; replaces the single-cycle all-inputs-at-once FC.

Parameters:
- IN_LEN, 1152, elements per frame (12*12*8).
- N_OUT, 10, output neurons/classes.
- DATA_W, 69, signed activation width.
- WEIGHT_W, 32, signed weight width.
- ACC_W, DATA_W+WEIGHT_W+$clog2(IN_LEN) (112), signed accumulator/score width.
- IDX_W, $clog2(N_OUT) (min 1), class index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  signed activation.
- in_weight  in  N_OUT*WEIGHT_W  signed weights; lane k at [k*WEIGHT_W +: WEIGHT_W].
- in_last  in  1  marks final element of frame.
- out_valid  out  1  scores/class valid.
- out_ready  in  1  downstream accepts.
- out_score  out  N_OUT*ACC_W  signed scores; lane k at [k*ACC_W +: ACC_W].
- out_class  out  IDX_W  argmax index.
- frame_err  out  1  sticky: in_last position disagreed with IN_LEN.

Behaviour:
- Reset (rst low, async): state=IDLE, all accumulators 0, elem count 0, out_valid 0, out_score 0, out_class 0, frame_err 0, in_ready 0 during reset. in_ready becomes 1 on the first edge after release.
- States:
  - IDLE: in_ready=1. Accepted beat clears the accumulators, loads acc[k]=in_data*w[k], count=1, and moves to ACCUM. If that beat is already the last, moves to SCAN instead.
  - ACCUM: in_ready=1. Each accepted beat does acc[k]+=in_data*w[k] (full-precision signed product, sign-extended to ACC_W; no saturation or truncation) and count++.
  - Frame end is the beat where count reaches IN_LEN or in_last=1, whichever is first. Go to SCAN. If in_last and (count==IN_LEN) disagree on that beat, set frame_err; it clears only on reset.
  - SCAN: in_ready=0. One lane compared per cycle, idx 0..N_OUT-1; best starts as lane 0. Strictly-greater signed compare, so the lowest index wins ties. After lane N_OUT-1, go to DONE.
  - DONE: out_valid=1; out_score and out_class stable until out_ready=1. out_ready is sampled with out_valid: on that edge out_valid drops and state goes to IDLE.
- Latency: out_valid rises N_OUT cycles after the edge that accepts the final beat.
- Throughput: one element per cycle; frame period IN_LEN+N_OUT+1 cycles with out_ready held high.
- in_valid low in ACCUM: stall, accumulators hold, no timeout.
- out_valid does not depend on out_ready; in_ready is 0 in SCAN and DONE (no frame overlap).
- Reset mid-frame: everything returns to reset values; the partial frame is discarded.

Optional Feature:
- Macro FC_BIAS_EN.
- Defined: adds input in_bias (N_OUT*WEIGHT_W, signed, sampled on the first accepted beat of a frame). The first beat loads acc[k]=bias[k]+in_data*w[k].
- Undefined: port absent; the first beat loads the product only. Timing is identical either way.

Decomposition:
- Package fc_pkg: default constants (FC_IN_LEN, FC_N_OUT, FC_DATA_W, FC_WEIGHT_W), the state enum type (IDLE, ACCUM, SCAN, DONE), and an ACC_W helper function.
- Sub-module fc_mac_lane: one signed multiply-accumulate lane with load/accumulate/hold controls.
- Top instantiates N_OUT fc_mac_lane via generate; the FSM, counter and argmax scan stay in the top.

Test Plan:
- IN_LEN=4, N_OUT=3. Data 1,2,3,4; lane weights (1,1,1,1), (-1,-1,-1,-1), (2,0,0,0); in_last on beat 4, back-to-back -> scores 10, -10, 2; class 0; out_valid 3 cycles after the last accept; frame_err 0.
- Signed extremes: data = -2^(DATA_W-1), weight = -2^(WEIGHT_W-1), for all IN_LEN beats -> score exactly IN_LEN*2^(DATA_W+WEIGHT_W-2) with no overflow.
- Tie: all lanes produce equal scores -> out_class 0. Lane 2 strictly greatest -> out_class 2.
- Backpressure: out_ready held low 20 cycles -> out_valid, out_score and out_class stable, in_ready 0; out_ready high -> IDLE next cycle and the next frame accepted.
- in_valid gaps mid-frame and in_last on beat 3 of IN_LEN=4 -> frame ends early, frame_err=1 and stays 1 across the following good frame.
- rst asserted during ACCUM beat 2 -> all outputs 0 immediately; the next full frame gives correct scores. With FC_BIAS_EN, bias (5,0,0) gives scores 15, -10, 2.
